uart_tx_frame_gen: RTL and testbench

//  UART transmitter: serializes one parallel byte into a framed line, LSB first.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_bit_timer.sv | 41 ++++
 rtl/uart_tx_frame_gen.sv | 111 +++++++++++
 tb/tb_uart_tx_frame_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encodings, parity selectors and default widths.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_PRESC_WIDTH = 6;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit timing for the UART transmitter: edge counter over P clocks plus data bit index.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned PRESC_WIDTH = DEF_PRESC_WIDTH,
  parameter int unsigned IDX_WIDTH   = idx_width(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [PRESC_WIDTH-1:0] p,
  input  logic                   count_bits,
  output logic                   bit_done,
  output logic [IDX_WIDTH-1:0]   bit_idx
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

  logic [PRESC_WIDTH-1:0] edge_cnt;

  // p is never 0 here; the top substitutes 1 when it latches prescale.
  assign bit_done = enable && (edge_cnt == p - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_idx  <= '0;
    end else if (enable) begin
      if (bit_done) begin
        edge_cnt <= '0;
        if (count_bits) begin
          bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
        end
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: latches one request, then sends start, data LSB first, optional parity, stop.
module uart_tx_frame_gen
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned PRESC_WIDTH = DEF_PRESC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic                   par_en,
  input  logic                   par_typ,
  input  logic [DATA_WIDTH-1:0]  p_data,
  input  logic                   data_valid,
  output logic                   tx_out,
  output logic                   busy
);

  localparam int unsigned IDX_WIDTH = idx_width(DATA_WIDTH);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

  tx_state_t              state;
  logic [DATA_WIDTH-1:0]  data_sh;
  logic                   par_en_q;
  logic                   par_bit_q;
  logic [PRESC_WIDTH-1:0] presc_q;
  logic                   bit_done;
  logic [IDX_WIDTH-1:0]   bit_idx;

  uart_tx_bit_timer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PRESC_WIDTH (PRESC_WIDTH),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .enable     (state != TX_IDLE),
    .p          (presc_q),
    .count_bits (state == TX_DATA),
    .bit_done   (bit_done),
    .bit_idx    (bit_idx)
  );

  // Data is kept as a shift register and parity is resolved at acceptance,
  // so tx_out always comes straight from a flop with no wide mux.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= TX_IDLE;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      data_sh   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      presc_q   <= PRESC_WIDTH'(1);
    end else begin
      case (state)
        TX_IDLE: begin
          if (data_valid) begin
            data_sh   <= p_data;
            par_en_q  <= par_en;
            par_bit_q <= (^p_data) ^ (par_typ == PAR_ODD);
            presc_q   <= (prescale == '0) ? PRESC_WIDTH'(1) : prescale;
            state     <= TX_START;
            tx_out    <= 1'b0;
            busy      <= 1'b1;
          end
        end
        TX_START: begin
          if (bit_done) begin
            state  <= TX_DATA;
            tx_out <= data_sh[0];
          end
        end
        TX_DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_IDX) begin
              if (par_en_q) begin
                state  <= TX_PARITY;
                tx_out <= par_bit_q;
              end else begin
                state  <= TX_STOP;
                tx_out <= 1'b1;
              end
            end else begin
              data_sh <= data_sh >> 1;
              tx_out  <= data_sh[1];
            end
          end
        end
        TX_PARITY: begin
          if (bit_done) begin
            state  <= TX_STOP;
            tx_out <= 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_done) begin
            state <= TX_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= TX_IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen: frames are sampled every clock and compared to hand-built bit patterns.
module tb_uart_tx_frame_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] p_data;
  logic       data_valid;
  logic       tx_out;
  logic       busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  uart_tx_frame_gen #(
    .DATA_WIDTH  (8),
    .PRESC_WIDTH (6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at the first negedge after acceptance; fr[k] is the k-th bit on the line.
  task automatic collect(input logic [10:0] fr, input int unsigned nbits,
                         input int unsigned p, input string tag);
    logic        q[$];
    int unsigned n;
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      q.push_back(tx_out);
      n++;
      @(negedge clk);
    end
    chk({tag, "_len"}, n, nbits * p);
    if (n == nbits * p) begin
      for (int unsigned b = 0; b < nbits; b++) begin
        chk($sformatf("%s_b%0d_head", tag, b), 32'(q[b*p]), 32'(fr[b]));
        chk($sformatf("%s_b%0d_tail", tag, b), 32'(q[b*p+p-1]), 32'(fr[b]));
      end
    end
    chk({tag, "_idle"}, tx_out, 1);
  endtask

  task automatic send(input logic [5:0] presc, input logic pe, input logic pt,
                      input logic [7:0] d, input logic [10:0] fr,
                      input int unsigned nbits, input int unsigned p, input string tag);
    @(negedge clk);
    prescale   = presc;
    par_en     = pe;
    par_typ    = pt;
    p_data     = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    p_data     = ~d;
    par_en     = ~pe;
    par_typ    = ~pt;
    prescale   = presc + 6'd3;
    collect(fr, nbits, p, tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    prescale   = 6'd8;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    p_data     = 8'h00;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b1;

    send(6'd8,  1'b1, 1'b0, 8'hA5, 11'b10101001010, 11, 8,  "t1_a5");
    send(6'd16, 1'b1, 1'b1, 8'h01, 11'b10000000010, 11, 16, "t2_odd01");
    send(6'd16, 1'b1, 1'b1, 8'h00, 11'b11000000000, 11, 16, "t2_odd00");
    send(6'd8,  1'b0, 1'b0, 8'hFF, 11'b01111111110, 10, 8,  "t3_nopar");

    // data_valid held high across two back-to-back frames
    @(negedge clk);
    prescale   = 6'd8;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    p_data     = 8'h3C;
    data_valid = 1'b1;
    @(negedge clk);
    p_data  = 8'hC3;
    par_typ = 1'b1;
    collect(11'b10001111000, 11, 8, "t4_first");
    @(negedge clk);
    data_valid = 1'b0;
    chk("t4_restart_busy", busy, 1);
    collect(11'b11110000110, 11, 8, "t4_second");

    // reset pulse in the middle of data bit 4
    @(negedge clk);
    prescale   = 6'd8;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    p_data     = 8'h96;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (43) @(negedge clk);
    chk("t5_pre_busy", busy, 1);
    chk("t5_pre_bit4", tx_out, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_tx", tx_out, 1);
    chk("t5_rst_busy", busy, 0);
    rst = 1'b1;
    send(6'd8, 1'b1, 1'b0, 8'h96, 11'b10100101100, 11, 8, "t5_after");

    send(6'd1, 1'b1, 1'b0, 8'h5A, 11'b10010110100, 11, 1, "t6_p1");
    send(6'd0, 1'b1, 1'b0, 8'h5A, 11'b10010110100, 11, 1, "t6_p0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
